axi_memory_master_burst: RTL and testbench
==========================================

# axi_memory_master_burst

AXI4 write-only burst master converting a single-cycle write command plus a per-cycle data stream into one AXI4 write burst (AW, W, B channels). It sits between the frame memory writer, which issues `start_write` with address, length and data, and the AXI memory slave. A local burst buffer absorbs the command-side data, so the producer needs no backpressure.

## Interface

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe is DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width
- MAX_BURST, 16, burst buffer depth; longest burst in beats

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-high (asserted = 1)
- start_write  in  1  one-cycle command pulse
- write_id  in  ID_WIDTH  burst ID
- write_addr  in  ADDR_WIDTH  burst start address
- write_len  in  32  burst length in beats
- write_size  in  3  AXI beat size code
- write_burst  in  2  AXI burst type
- write_data  in  DATA_WIDTH  beat data, one beat per cycle from command cycle
- write_strb  in  DATA_WIDTH/8  beat byte strobes
- start_read  in  1  reserved, ignored
- awid/awaddr/awlen(8)/awsize(3)/awburst(2)/awvalid  out  write address channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  write data channel
- wready  in  1
- bid(ID_WIDTH)/bresp(2)/bvalid  in  write response channel
- bready  out  1

## Operation

- Effective length L = write_len clamped to 1..MAX_BURST (0 becomes 1, values above MAX_BURST become MAX_BURST).
- States: IDLE, ADDR, DATA, RESP.
- IDLE: on start_write, latch id/addr/L/size/burst, store write_data/strb as buffer entry 0, set in-count = 1, go to ADDR.
- Capture is independent of state: each cycle after the command cycle, while in-count < L, store write_data/strb at buffer[in-count] and increment in-count.
- ADDR: awvalid=1, awlen=L-1, other AW fields latched. On awready, go to DATA.
- DATA: wvalid=1 while out-ptr < in-count; wdata/wstrb=buffer[out-ptr]; wlast=1 when out-ptr==L-1. On wvalid&wready, increment out-ptr. After the wlast handshake, go to RESP.
- RESP: bready=1. On bvalid, go to IDLE. bresp and bid are not acted on.
- start_write outside IDLE is ignored, with no effect on the buffer.
- awburst and awsize are passed through verbatim. Address increment is the slave's responsibility.

## Timing

- Reset: all outputs 0; state IDLE; counters 0.
- Command at edge T:
  - awvalid rises at T+1.
  - With awready already high, AW completes at T+1.
  - First wvalid at T+2.
  - Beats stream at one per cycle while wready=1.
  - wlast is on beat L-1 at T+1+L.
- awvalid and wvalid, once asserted, hold with stable payload until handshake (AXI rule).
- wready low stalls out-ptr; capture continues unaffected.
- awready late by N cycles delays the whole W phase by N.
- bvalid in the same cycle RESP is entered is accepted; IDLE is reached the next cycle.
- The earliest next accepted command is the cycle after returning to IDLE.
- Reset asserted mid-burst aborts immediately. All valids drop asynchronously and buffer contents are discarded.

## Structure

- Package `axi_mem_pkg`: burst-type constants FIXED=0, INCR=1, WRAP=2; size codes; master state enum; response codes OKAY=0, SLVERR=2.
- Sub-module `axi_wbuf`: MAX_BURST-deep register buffer holding data and strobe, with write index and read index. The top FSM owns the counters.

## Test plan

- Reset: hold resetn=1 for 2 cycles -> all outputs 0. Release -> IDLE.
- 4-beat INCR burst:
  - Stimulus: start_write, addr 0x10, len 4, size 2, data 1,2,3,4 on consecutive cycles; slave ready always.
  - Response: awlen=3, awaddr=0x10; wdata 1,2,3,4 on consecutive cycles; wlast only on 4; bready until bvalid.
- Backpressure:
  - Stimulus: as above, but awready delayed 3 cycles and wready low on alternate cycles.
  - Response: same 4 beats in order, payload stable during stalls, exactly one wlast.
- Length bounds:
  - len 0 -> awlen=0, one beat with wlast.
  - len 40 -> awlen=15, 16 beats.
- Busy command: second start_write during DATA -> ignored; exactly one AW handshake.
- Back-to-back frames: four 8-beat bursts at addresses 0, 32, 64, 96 with data (i+1)*(frame+1) -> all beats appear in order, one B per burst.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared constants, state encoding and helpers for the AXI4 write burst master.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [2:0] SIZE_1B  = 3'd0;
    localparam logic [2:0] SIZE_2B  = 3'd1;
    localparam logic [2:0] SIZE_4B  = 3'd2;
    localparam logic [2:0] SIZE_8B  = 3'd3;
    localparam logic [2:0] SIZE_16B = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } mst_state_t;

    // Requested beat count forced into 1..max_len.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/axi_wbuf.sv
// Register-file burst buffer: one write port from the producer stream, one
// combinational read port feeding the W channel output registers.
module axi_wbuf
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic [IDX_W-1:0]        i_rd_idx,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic [DATA_WIDTH/8-1:0] o_rd_strb
);

    logic [DATA_WIDTH-1:0]   r_data [DEPTH];
    logic [DATA_WIDTH/8-1:0] r_strb [DEPTH];

    // Storage needs no reset: validity is tracked by the owner's counters.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
            r_strb[i_wr_idx] <= i_wr_strb;
        end
    end

    assign o_rd_data = r_data[i_rd_idx];
    assign o_rd_strb = r_strb[i_rd_idx];

endmodule

// File: rtl/axi_memory_master_burst.sv
// AXI4 write-only burst master: one command plus a per-cycle data stream becomes
// one AW/W/B burst, with the stream absorbed by a local buffer.
module axi_memory_master_burst
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start_write,
    input  logic [ID_WIDTH-1:0]     write_id,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [31:0]             write_len,
    input  logic [2:0]              write_size,
    input  logic [1:0]              write_burst,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    start_read,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(MAX_BURST);
    localparam int SW = DATA_WIDTH / 8;

    mst_state_t              r_state;
    logic [CW-1:0]           r_len;
    logic [CW-1:0]           r_in_cnt;
    logic [CW-1:0]           r_out_ptr;
    logic [ID_WIDTH-1:0]     r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [2:0]              r_awsize;
    logic [1:0]              r_awburst;
    logic                    r_awvalid;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [SW-1:0]           r_wstrb;
    logic                    r_wlast;
    logic                    r_wvalid;
    logic                    r_bready;

    logic [31:0]             w_len_clamped;
    logic [CW-1:0]           w_len_eff;
    logic                    w_cmd;
    logic                    w_wr_en;
    logic [CW-1:0]           w_wr_cnt;
    logic                    w_w_fire;
    logic [CW-1:0]           w_ptr_nxt;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [SW-1:0]           w_rd_strb;
    logic                    w_unused;

    assign w_len_clamped = clamp_len(write_len, 32'(MAX_BURST));
    assign w_len_eff     = w_len_clamped[CW-1:0];
    assign w_cmd         = start_write && (r_state == ST_IDLE);
    // A new command restarts capture at entry 0; otherwise keep filling up to L.
    assign w_wr_en       = w_cmd || (r_in_cnt < r_len);
    assign w_wr_cnt      = w_cmd ? {CW{1'b0}} : r_in_cnt;
    assign w_w_fire      = r_wvalid && wready;
    assign w_ptr_nxt     = r_out_ptr + {{(CW-1){1'b0}}, w_w_fire};
    assign w_unused      = &{1'b0, start_read, bid, bresp, w_len_clamped[31:CW]};

    axi_wbuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_BURST),
        .IDX_W      (IW)
    ) u_wbuf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_cnt[IW-1:0]),
        .i_wr_data (write_data),
        .i_wr_strb (write_strb),
        .i_rd_idx  (w_ptr_nxt[IW-1:0]),
        .o_rd_data (w_rd_data),
        .o_rd_strb (w_rd_strb)
    );

    // Burst FSM, capture counter and registered AXI outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state   <= ST_IDLE;
            r_len     <= {CW{1'b0}};
            r_in_cnt  <= {CW{1'b0}};
            r_out_ptr <= {CW{1'b0}};
            r_awid    <= {ID_WIDTH{1'b0}};
            r_awaddr  <= {ADDR_WIDTH{1'b0}};
            r_awlen   <= 8'd0;
            r_awsize  <= 3'd0;
            r_awburst <= 2'd0;
            r_awvalid <= 1'b0;
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_wstrb   <= {SW{1'b0}};
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_in_cnt <= w_wr_cnt + CW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_write) begin
                        r_len     <= w_len_eff;
                        r_out_ptr <= {CW{1'b0}};
                        r_awid    <= write_id;
                        r_awaddr  <= write_addr;
                        r_awlen   <= 8'(w_len_eff - CW'(1));
                        r_awsize  <= write_size;
                        r_awburst <= write_burst;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Entry 0 was captured with the command, so beat 0 preloads here.
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= w_rd_data;
                        r_wstrb   <= w_rd_strb;
                        r_wlast   <= (w_ptr_nxt == r_len - CW'(1));
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_out_ptr <= w_ptr_nxt;
                    if (w_w_fire && r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end else if (!r_wvalid || w_w_fire) begin
                        // Payload only advances after a handshake, keeping it stable while stalled.
                        if (w_ptr_nxt < r_in_cnt) begin
                            r_wvalid <= 1'b1;
                            r_wdata  <= w_rd_data;
                            r_wstrb  <= w_rd_strb;
                            r_wlast  <= (w_ptr_nxt == r_len - CW'(1));
                        end else begin
                            r_wvalid <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign awid    = r_awid;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awsize  = r_awsize;
    assign awburst = r_awburst;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = r_wlast;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

endmodule

// File: tb/tb_axi_memory_master_burst.sv
// Directed self-checking bench for axi_memory_master_burst with a small AXI slave loop.
module tb_axi_memory_master_burst;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_write;
    logic [3:0]  write_id;
    logic [31:0] write_addr;
    logic [31:0] write_len;
    logic [2:0]  write_size;
    logic [1:0]  write_burst;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        start_read;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] src [64];
    int          aw_cnt, aw_k, nbeats, wlast_cnt, wlast_idx, b_cnt, b_k, stall_err;
    logic [31:0] aw_addr_s;
    logic [7:0]  aw_len_s;
    logic [3:0]  aw_id_s;
    logic [2:0]  aw_size_s;
    logic [1:0]  aw_burst_s;
    logic [31:0] beat_data [64];
    logic [3:0]  beat_strb [64];
    int          beat_k [64];

    axi_memory_master_burst dut (
        .clk(clk), .resetn(resetn), .start_write(start_write), .write_id(write_id),
        .write_addr(write_addr), .write_len(write_len), .write_size(write_size),
        .write_burst(write_burst), .write_data(write_data), .write_strb(write_strb),
        .start_read(start_read), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        start_write = 1'b0; write_id = 4'd0; write_addr = 32'd0; write_len = 32'd0;
        write_size = 3'd0; write_burst = 2'd0; write_data = 32'd0; write_strb = 4'd0;
        start_read = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
    endtask

    // Issue one command at iteration 0 and act as the slave until the B handshake.
    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] len,
                            input int aw_delay, input bit w_alt, input int busy_k);
        bit done = 1'b0;
        bit b_pend = 1'b0;
        bit prev_wstall = 1'b0;
        bit prev_awstall = 1'b0;
        logic [31:0] prev_wdata = 32'd0;
        logic [31:0] prev_awaddr = 32'd0;
        logic prev_wlast = 1'b0;
        aw_cnt = 0; aw_k = -1; nbeats = 0; wlast_cnt = 0; wlast_idx = -1;
        b_cnt = 0; b_k = -1; stall_err = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            start_write = (k == 0) || (k == busy_k);
            write_id    = (k == 0) ? id : 4'hF;
            write_addr  = (k == 0) ? addr : 32'h0000_BAD0;
            write_len   = (k == 0) ? len : 32'd2;
            write_size  = (k == 0) ? 3'd2 : 3'd0;
            write_burst = (k == 0) ? 2'd1 : 2'd0;
            write_data  = src[k % 64];
            write_strb  = 4'(k + 1);
            awready     = (k >= aw_delay);
            wready      = w_alt ? ((k % 2) == 0) : 1'b1;
            bvalid      = b_pend;
            bid         = id;
            bresp       = 2'd0;
            if (prev_awstall && (!awvalid || awaddr !== prev_awaddr)) stall_err++;
            if (prev_wstall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast)) stall_err++;
            prev_awstall = awvalid && !awready;
            prev_awaddr  = awaddr;
            prev_wstall  = wvalid && !wready;
            prev_wdata   = wdata;
            prev_wlast   = wlast;
            if (awvalid && awready) begin
                aw_cnt++; aw_k = k; aw_addr_s = awaddr; aw_len_s = awlen;
                aw_id_s = awid; aw_size_s = awsize; aw_burst_s = awburst;
            end
            if (wvalid && wready && nbeats < 64) begin
                beat_data[nbeats] = wdata; beat_strb[nbeats] = wstrb; beat_k[nbeats] = k;
                if (wlast) begin
                    wlast_cnt++; wlast_idx = nbeats; b_pend = 1'b1;
                end
                nbeats++;
            end
            if (bvalid && bready) begin
                b_cnt++; b_k = k; b_pend = 1'b0; done = 1'b1;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        n_vec++;
        if (done !== 1'b1) begin n_err++; $display("FAIL burst_timeout: B handshake not seen within 200 cycles (addr %0h)", addr); end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({awvalid, wvalid, wlast, bready, awlen, awaddr, wdata, wstrb, awid, awsize, awburst} !== 89'd0) begin
            n_err++; $display("FAIL reset_outputs: got awv=%0b wv=%0b bready=%0b awaddr=%0h wdata=%0h, required all 0",
                              awvalid, wvalid, bready, awaddr, wdata);
        end
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({awvalid, wvalid, bready} !== 3'b000) begin
            n_err++; $display("FAIL idle_after_reset: valids=%0b required 000", {awvalid, wvalid, bready});
        end
    endtask

    task automatic test_incr4();
        for (int i = 0; i < 64; i++) src[i] = 32'(i + 1);
        do_burst(4'h5, 32'h10, 32'd4, 0, 1'b0, -1);
        n_vec++; if (aw_cnt !== 1) begin n_err++; $display("FAIL incr4_aw_count: got %0d required 1", aw_cnt); end
        n_vec++; if (aw_addr_s !== 32'h10) begin n_err++; $display("FAIL incr4_awaddr: got %0h required 10", aw_addr_s); end
        n_vec++; if (aw_len_s !== 8'd3) begin n_err++; $display("FAIL incr4_awlen: got %0d required 3", aw_len_s); end
        n_vec++; if ({aw_id_s, aw_size_s, aw_burst_s} !== {4'h5, 3'd2, 2'd1}) begin
            n_err++; $display("FAIL incr4_aw_fields: got id=%0h size=%0d burst=%0d required 5/2/1", aw_id_s, aw_size_s, aw_burst_s);
        end
        n_vec++; if (aw_k !== 1) begin n_err++; $display("FAIL incr4_aw_cycle: got %0d required 1", aw_k); end
        n_vec++; if (nbeats !== 4) begin n_err++; $display("FAIL incr4_beats: got %0d required 4", nbeats); end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (beat_data[j] !== 32'(j + 1) || beat_strb[j] !== 4'(j + 1) || beat_k[j] !== j + 2) begin
                n_err++; $display("FAIL incr4_beat%0d: got data=%0h strb=%0h cyc=%0d required %0h/%0h/%0d",
                                  j, beat_data[j], beat_strb[j], beat_k[j], j + 1, j + 1, j + 2);
            end
        end
        n_vec++; if (wlast_cnt !== 1 || wlast_idx !== 3) begin
            n_err++; $display("FAIL incr4_wlast: got count=%0d idx=%0d required 1/3", wlast_cnt, wlast_idx);
        end
        n_vec++; if (b_cnt !== 1 || b_k !== 6) begin n_err++; $display("FAIL incr4_b: got count=%0d cyc=%0d required 1/6", b_cnt, b_k); end
        n_vec++; if ({awvalid, wvalid, bready} !== 3'b000) begin
            n_err++; $display("FAIL incr4_idle_after: valids=%0b required 000", {awvalid, wvalid, bready});
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) src[i] = 32'hC0DE_0000 + 32'(i);
        do_burst(4'h2, 32'h200, 32'd4, 4, 1'b1, -1);
        n_vec++; if (aw_k !== 4 || aw_cnt !== 1) begin n_err++; $display("FAIL bp_aw: got cyc=%0d count=%0d required 4/1", aw_k, aw_cnt); end
        n_vec++; if (nbeats !== 4) begin n_err++; $display("FAIL bp_beats: got %0d required 4", nbeats); end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (beat_data[j] !== 32'hC0DE_0000 + 32'(j)) begin
                n_err++; $display("FAIL bp_beat%0d: got %0h required %0h", j, beat_data[j], 32'hC0DE_0000 + 32'(j));
            end
        end
        n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d payload changes during stall required 0", stall_err); end
        n_vec++; if (wlast_cnt !== 1 || wlast_idx !== 3) begin
            n_err++; $display("FAIL bp_wlast: got count=%0d idx=%0d required 1/3", wlast_cnt, wlast_idx);
        end
    endtask

    task automatic test_length_bounds();
        for (int i = 0; i < 64; i++) src[i] = 32'hA000_0000 + 32'(i);
        do_burst(4'h1, 32'h300, 32'd0, 0, 1'b0, -1);
        n_vec++; if (aw_len_s !== 8'd0) begin n_err++; $display("FAIL len0_awlen: got %0d required 0", aw_len_s); end
        n_vec++; if (nbeats !== 1 || beat_data[0] !== 32'hA000_0000 || wlast_idx !== 0) begin
            n_err++; $display("FAIL len0_beat: got beats=%0d data=%0h lastidx=%0d required 1/a0000000/0", nbeats, beat_data[0], wlast_idx);
        end
        do_burst(4'h3, 32'h400, 32'd40, 0, 1'b0, -1);
        n_vec++; if (aw_len_s !== 8'd15) begin n_err++; $display("FAIL len40_awlen: got %0d required 15", aw_len_s); end
        n_vec++; if (nbeats !== 16 || wlast_cnt !== 1 || wlast_idx !== 15) begin
            n_err++; $display("FAIL len40_beats: got beats=%0d lasts=%0d lastidx=%0d required 16/1/15", nbeats, wlast_cnt, wlast_idx);
        end
        for (int j = 0; j < 16; j++) begin
            n_vec++;
            if (beat_data[j] !== 32'hA000_0000 + 32'(j)) begin
                n_err++; $display("FAIL len40_beat%0d: got %0h required %0h", j, beat_data[j], 32'hA000_0000 + 32'(j));
            end
        end
    endtask

    task automatic test_busy_command();
        for (int i = 0; i < 64; i++) src[i] = 32'h5500_0000 + 32'(i * 3);
        do_burst(4'h7, 32'h500, 32'd4, 0, 1'b0, 3);
        n_vec++; if (aw_cnt !== 1 || aw_addr_s !== 32'h500) begin
            n_err++; $display("FAIL busy_aw: got count=%0d addr=%0h required 1/500", aw_cnt, aw_addr_s);
        end
        n_vec++; if (nbeats !== 4 || beat_data[3] !== 32'h5500_0009 || beat_data[1] !== 32'h5500_0003) begin
            n_err++; $display("FAIL busy_beats: got beats=%0d b1=%0h b3=%0h required 4/55000003/55000009", nbeats, beat_data[1], beat_data[3]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (awvalid !== 1'b0) begin n_err++; $display("FAIL busy_no_second_aw: awvalid=%0b required 0", awvalid); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 64; i++) src[i] = 32'((i + 1) * (f + 1));
            do_burst(4'(f), 32'(f * 32), 32'd8, 0, 1'b0, -1);
            n_vec++; if (aw_cnt !== 1 || aw_addr_s !== 32'(f * 32) || aw_len_s !== 8'd7 || aw_k !== 1) begin
                n_err++; $display("FAIL b2b_aw%0d: got count=%0d addr=%0h len=%0d cyc=%0d required 1/%0h/7/1",
                                  f, aw_cnt, aw_addr_s, aw_len_s, aw_k, f * 32);
            end
            for (int j = 0; j < 8; j++) begin
                n_vec++;
                if (j >= nbeats || beat_data[j] !== 32'((j + 1) * (f + 1))) begin
                    n_err++; $display("FAIL b2b_f%0d_beat%0d: got %0h required %0h", f, j, beat_data[j], (j + 1) * (f + 1));
                end
            end
            n_vec++; if (nbeats !== 8 || b_cnt !== 1 || wlast_idx !== 7) begin
                n_err++; $display("FAIL b2b_f%0d_count: got beats=%0d b=%0d lastidx=%0d required 8/1/7", f, nbeats, b_cnt, wlast_idx);
            end
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 64; i++) src[i] = 32'h7700_0000 + 32'(i);
        start_write = 1'b1; write_id = 4'h9; write_addr = 32'h40; write_len = 32'd8;
        write_size = 3'd2; write_burst = 2'd1; write_data = src[0]; write_strb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        @(posedge clk); #1;
        start_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (wvalid !== 1'b1) begin n_err++; $display("FAIL abort_pre_wvalid: got %0b required 1", wvalid); end
        #2;
        resetn = 1'b1;
        #1;
        n_vec++; if ({awvalid, wvalid, bready, wlast} !== 4'b0000) begin
            n_err++; $display("FAIL abort_async_drop: valids=%0b required 0000", {awvalid, wvalid, bready, wlast});
        end
        idle_inputs();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        do_burst(4'h4, 32'h80, 32'd2, 0, 1'b0, -1);
        n_vec++; if (aw_cnt !== 1 || aw_addr_s !== 32'h80 || nbeats !== 2 || beat_data[1] !== 32'h7700_0001) begin
            n_err++; $display("FAIL abort_recovery: got aw=%0d addr=%0h beats=%0d b1=%0h required 1/80/2/77000001",
                              aw_cnt, aw_addr_s, nbeats, beat_data[1]);
        end
    endtask

    initial begin
        test_reset();
        test_incr4();
        test_backpressure();
        test_length_bounds();
        test_busy_command();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
